// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared state encoding and default constants for the parking gate
package parking_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_OPEN_ENTRY = 2'd1,
    ST_OPEN_EXIT  = 2'd2,
    ST_CLOSING    = 2'd3
  } gate_state_t;

  typedef enum logic {
    LANE_ENTRY = 1'b0,
    LANE_EXIT  = 1'b1
  } lane_t;

  localparam int DEF_CAPACITY     = 100;
  localparam int DEF_TIMEOUT      = 1000;
  localparam int DEF_CLOSE_CYCLES = 4;

endpackage

// File: rtl/occupancy_counter.sv
// rtl/occupancy_counter.sv - saturating up/down vehicle counter with full flag
module occupancy_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic [7:0] max,
  output logic [7:0] count,
  output logic       full
);

  // Count passes in either direction, pinned to the range 0..max.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 8'd0;
    end else if (inc && !dec && (count < max)) begin
      count <= count + 8'd1;
    end else if (dec && !inc && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign full = (count == max);

endmodule

// File: rtl/parking_gate_arbiter.sv
// rtl/parking_gate_arbiter.sv - single-barrier entry/exit arbiter with timeout and occupancy
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int CAPACITY     = DEF_CAPACITY,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic       pass_sensor,
  output logic       entry_gnt,
  output logic       exit_gnt,
  output logic       open_gate,
  output logic       close_gate,
  output logic       full,
  output logic       timeout_alarm,
  output logic [7:0] occupancy
);

  localparam int WAIT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int CLOSE_W = (CLOSE_CYCLES > 1) ? $clog2(CLOSE_CYCLES + 1) : 1;

  gate_state_t        state, state_d;
  lane_t              last_served;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [CLOSE_W-1:0] close_cnt;
  logic               inc, dec;
  logic               entry_ok;
  logic               wait_done;
  logic               close_done;

  // An entry is only worth granting when there is room for the car.
  assign entry_ok   = entry_req && !full;
  assign wait_done  = (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign close_done = (close_cnt == CLOSE_W'(CLOSE_CYCLES - 1));

  occupancy_counter u_occupancy (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .dec   (dec),
    .max   (8'(CAPACITY)),
    .count (occupancy),
    .full  (full)
  );

  // State, counters and round-robin memory; counters restart whenever their state is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      last_served <= LANE_EXIT;
      wait_cnt    <= '0;
      close_cnt   <= '0;
    end else begin
      state <= state_d;
      if ((state == ST_IDLE) && (state_d == ST_OPEN_ENTRY)) last_served <= LANE_ENTRY;
      if ((state == ST_IDLE) && (state_d == ST_OPEN_EXIT))  last_served <= LANE_EXIT;
      wait_cnt  <= ((state != ST_IDLE) && (state != ST_CLOSING) && (state_d == state))
                   ? wait_cnt + 1'b1 : '0;
      close_cnt <= ((state == ST_CLOSING) && (state_d == ST_CLOSING))
                   ? close_cnt + 1'b1 : '0;
    end
  end

  // Next-state selection and state-decoded barrier/grant outputs.
  always_comb begin
    state_d       = state;
    entry_gnt     = 1'b0;
    exit_gnt      = 1'b0;
    open_gate     = 1'b0;
    close_gate    = 1'b0;
    timeout_alarm = 1'b0;
    inc           = 1'b0;
    dec           = 1'b0;
    case (state)
      ST_IDLE: begin
        if (entry_ok && exit_req) begin
          state_d = (last_served == LANE_EXIT) ? ST_OPEN_ENTRY : ST_OPEN_EXIT;
        end else if (entry_ok) begin
          state_d = ST_OPEN_ENTRY;
        end else if (exit_req) begin
          state_d = ST_OPEN_EXIT;
        end
      end
      ST_OPEN_ENTRY, ST_OPEN_EXIT: begin
        open_gate = 1'b1;
        entry_gnt = (state == ST_OPEN_ENTRY) && (wait_cnt == '0);
        exit_gnt  = (state == ST_OPEN_EXIT) && (wait_cnt == '0);
        if (pass_sensor) begin
          inc     = (state == ST_OPEN_ENTRY);
          dec     = (state == ST_OPEN_EXIT);
          state_d = ST_CLOSING;
        end else if (wait_done) begin
          timeout_alarm = 1'b1;
          state_d       = ST_CLOSING;
        end
      end
      ST_CLOSING: begin
        close_gate = 1'b1;
        if (close_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// tb/tb_parking_gate_arbiter.sv - directed self-checking bench for parking_gate_arbiter
module tb_parking_gate_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic       pass_sensor = 1'b0;
  logic       entry_gnt, exit_gnt, open_gate, close_gate, full, timeout_alarm;
  logic [7:0] occupancy;

  int passed = 0;
  int total  = 0;

  parking_gate_arbiter #(
    .CAPACITY     (2),
    .TIMEOUT      (8),
    .CLOSE_CYCLES (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .entry_req     (entry_req),
    .exit_req      (exit_req),
    .pass_sensor   (pass_sensor),
    .entry_gnt     (entry_gnt),
    .exit_gnt      (exit_gnt),
    .open_gate     (open_gate),
    .close_gate    (close_gate),
    .full          (full),
    .timeout_alarm (timeout_alarm),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic serve_entry();
    entry_req = 1'b1;
    step();
    entry_req   = 1'b0;
    pass_sensor = 1'b1;
    step();
    pass_sensor = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    #12;
    check("reset_outputs", {entry_gnt, exit_gnt, open_gate, close_gate, full, timeout_alarm}, 0);
    check("reset_occupancy", occupancy, 0);

    // entry scenario: request in cycle 0, pass in cycle 5
    entry_req = 1'b1;
    rst = 1'b1;
    step();
    check("entry_gnt_c1", {entry_gnt, exit_gnt, open_gate}, 3'b101);
    entry_req = 1'b0;
    step();
    check("entry_gnt_c2", {entry_gnt, open_gate}, 2'b01);
    repeat (3) step();
    pass_sensor = 1'b1;
    #1;
    check("entry_no_alarm_c5", {open_gate, timeout_alarm}, 2'b10);
    step();
    pass_sensor = 1'b0;
    check("entry_close_c6", {open_gate, close_gate}, 2'b01);
    check("entry_occ", occupancy, 1);
    repeat (3) step();
    check("entry_close_c9", close_gate, 1);
    step();
    check("entry_idle_c10", {open_gate, close_gate}, 2'b00);

    // pass_sensor in IDLE is ignored
    pass_sensor = 1'b1;
    repeat (2) step();
    pass_sensor = 1'b0;
    check("idle_pass_ignored", {occupancy, open_gate}, {8'd1, 1'b0});

    // contention from reset
    rst = 1'b0;
    #1;
    check("rst_clears_occ", occupancy, 0);
    entry_req = 1'b1;
    exit_req  = 1'b1;
    #1;
    rst = 1'b1;
    step();
    check("cont_first_entry", {entry_gnt, exit_gnt}, 2'b10);
    entry_req   = 1'b0;
    pass_sensor = 1'b1;
    step();
    pass_sensor = 1'b0;
    check("cont_closing", {close_gate, occupancy}, {1'b1, 8'd1});
    repeat (4) step();
    check("cont_idle_c6", {exit_gnt, open_gate, close_gate}, 3'b000);
    step();
    check("cont_exit_c7", {exit_gnt, open_gate}, 2'b11);
    exit_req    = 1'b0;
    pass_sensor = 1'b1;
    step();
    pass_sensor = 1'b0;
    check("cont_exit_occ", occupancy, 0);
    repeat (4) step();

    // underflow
    exit_req = 1'b1;
    step();
    check("under_gnt", exit_gnt, 1);
    exit_req    = 1'b0;
    pass_sensor = 1'b1;
    step();
    pass_sensor = 1'b0;
    check("under_occ", occupancy, 0);
    repeat (4) step();

    // capacity
    serve_entry();
    serve_entry();
    check("cap_full", {occupancy, full}, {8'd2, 1'b1});
    entry_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("cap_blocked", {entry_gnt, open_gate}, 2'b00);
    end
    exit_req = 1'b1;
    step();
    check("cap_exit_gnt", {entry_gnt, exit_gnt}, 2'b01);
    exit_req    = 1'b0;
    pass_sensor = 1'b1;
    step();
    pass_sensor = 1'b0;
    check("cap_after_exit", {occupancy, full}, {8'd1, 1'b0});
    repeat (3) step();
    step();
    check("cap_idle", {entry_gnt, close_gate}, 2'b00);
    step();
    check("cap_pending_gnt", {entry_gnt, open_gate}, 2'b11);
    entry_req = 1'b0;

    // timeout with no pass, reusing the open entry
    repeat (6) step();
    check("to_open7_no_alarm", {open_gate, timeout_alarm}, 2'b10);
    step();
    check("to_open8_alarm", {open_gate, timeout_alarm}, 2'b11);
    step();
    check("to_closing", {open_gate, close_gate, timeout_alarm}, 3'b010);
    check("to_occ_same", occupancy, 1);
    repeat (4) step();

    // pass coinciding with timeout: pass wins
    exit_req = 1'b1;
    step();
    exit_req = 1'b0;
    repeat (7) step();
    pass_sensor = 1'b1;
    #1;
    check("coinc_no_alarm", {open_gate, timeout_alarm}, 2'b10);
    step();
    pass_sensor = 1'b0;
    check("coinc_occ", {close_gate, occupancy}, {1'b1, 8'd0});
    repeat (4) step();

    // reset during OPEN_EXIT
    serve_entry();
    exit_req = 1'b1;
    step();
    check("mid_open", {exit_gnt, open_gate}, 2'b11);
    rst = 1'b0;
    #1;
    check("mid_rst_outputs", {exit_gnt, open_gate, close_gate}, 3'b000);
    check("mid_rst_occ", occupancy, 0);
    exit_req = 1'b0;
    rst = 1'b1;
    step();
    check("post_rst_idle", {open_gate, close_gate, occupancy}, 10'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
